lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. Port names are clock and reset.
REQ-002 LOCK_CNT, default 4: consecutive matching words in SYNC needed to declare lock (legal range 1..15).
REQ-003 LOSS_CNT, default 3: consecutive mismatching words in LOCKED needed to drop lock (legal range 1..15).
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  in_data carries a word this cycle.
REQ-007 in_data  in  13  received word from the 13-bit generator stream.
REQ-008 clear_count  in  1  synchronous clear of err_count.
REQ-009 locked  out  1  checker is in the LOCKED state.
REQ-010 err_pulse  out  1  one-cycle flag: a word was counted as an error.
REQ-011 err_count  out  16  saturating count of errored words.
REQ-012 zero_err  out  1  one-cycle flag: an all-zero word was received (see Configuration).

Function
REQ-013 The next-state function SHALL be fb = d[12]^d[3]^d[2]^d[0] and next(d) = {d[11:0], fb}.
REQ-014 The FSM SHALL have three states: HUNT, SYNC and LOCKED. Cycles with in_valid=0 SHALL change no state, counter or expected value.
REQ-015 In HUNT, a valid word SHALL load expected with next(in_data), clear run, and move the FSM to SYNC.
REQ-016 In SYNC, a word equal to expected SHALL increment run and load expected with next(expected); when run reaches LOCK_CNT the FSM SHALL move to LOCKED.
REQ-017 In SYNC, a mismatching word SHALL load expected with next(in_data) and clear run, and the FSM SHALL stay in SYNC; no error is counted.
REQ-018 In LOCKED, expected SHALL advance by next(expected) on every valid word, independent of in_data (flywheel).
REQ-019 In LOCKED, a match SHALL clear miss; a mismatch SHALL assert err_pulse, increment err_count and increment miss.
REQ-020 When miss reaches LOSS_CNT, the FSM SHALL move to HUNT and locked SHALL fall in the same edge.
REQ-021 All outputs SHALL be registered, with one-cycle latency from the valid word to err_pulse, locked or zero_err.
REQ-022 err_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-023 clear_count SHALL zero err_count on the next edge; if it coincides with an error, the result SHALL be 0.
REQ-024 err_count SHALL hold its value across lock loss; only clear_count or reset changes it.

Reset
REQ-025 While reset is high: FSM=HUNT, expected=13'h000F, run=0, miss=0, locked=0, err_pulse=0, zero_err=0, err_count=0.
REQ-026 Reset asserted mid-stream SHALL abort immediately. After release, the checker SHALL reacquire from HUNT with no error counted.

Configuration
REQ-027 With LFSR_CHK_ZERO_DETECT_EN defined, a valid 13'h0000 word in any state SHALL assert zero_err and force the FSM to HUNT. If the FSM was LOCKED, the word SHALL also count as an error.
REQ-028 Without LFSR_CHK_ZERO_DETECT_EN, zero_err SHALL be tied 0 and an all-zero word SHALL be handled as an ordinary word.

Structure
REQ-029 Package lfsr_pkg SHALL hold the width constant (13), the seed 13'h000F, the tap positions and the FSM state enum.
REQ-030 Sub-module lfsr_step SHALL implement next(d) combinationally. Two instances are used: one on in_data and one on expected.

Verification
REQ-031 Clean stream after reset: 0x000F, 0x001F, 0x003F, ... -> locked=1 after 1+LOCK_CNT words; err_count stays 0.
REQ-032 Bit 5 flipped in one word while LOCKED -> exactly one err_pulse, err_count=1, locked stays 1.
REQ-033 LOSS_CNT=3 consecutive corrupted words while LOCKED -> err_count=3 and locked=0 one cycle after the third word; locked reasserts after a clean resync.
REQ-034 err_count preloaded to 0xFFFF by forced errors, then more errors -> err_count remains 0xFFFF; clear_count coinciding with an error -> 0.
REQ-035 in_valid gaps of random length inside a clean stream -> no errors, lock is kept.
REQ-036 With LFSR_CHK_ZERO_DETECT_EN: a 0x0000 word while LOCKED -> zero_err=1, err_count+1, locked=0. Without the macro: a stream of zeros -> locked=1, zero_err=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and types for the 13-bit LFSR stream checker.
// Generator polynomial taps: d[12], d[3], d[2], d[0]; next(d) = {d[11:0], fb}.
package lfsr_pkg;

  // Generator word width and seed loaded into the expected register on reset
  localparam int unsigned LFSR_W    = 13;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 13'h000F;

  // Individual feedback tap positions
  localparam int unsigned TAP_A = 12;
  localparam int unsigned TAP_B = 3;
  localparam int unsigned TAP_C = 2;
  localparam int unsigned TAP_D = 0;

  // Tap positions folded into a mask: feedback is the XOR-reduce of d & mask
  localparam logic [LFSR_W-1:0] LFSR_TAPS =
    (LFSR_W'(1) << TAP_A) | (LFSR_W'(1) << TAP_B) |
    (LFSR_W'(1) << TAP_C) | (LFSR_W'(1) << TAP_D);

  // Error counter width and the width of the run/miss counters (thresholds 1..15)
  localparam int unsigned CNT_W = 16;
  localparam int unsigned RUN_W = 4;

  // Checker synchronisation states
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

endpackage : lfsr_pkg

// File: rtl/lfsr_step.sv
// lfsr_step: combinational single-step advance of the 13-bit generator.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] d_i,
  output logic [LFSR_W-1:0] next_o
);

  logic fb;

  // Feedback bit is the parity of the tapped bits; shift it in at the LSB
  always_comb begin
    fb     = ^(d_i & LFSR_TAPS);
    next_o = {d_i[LFSR_W-2:0], fb};
  end

endmodule : lfsr_step

// File: rtl/lfsr_checker.sv
// lfsr_checker: acquires lock on a 13-bit LFSR word stream, then flywheels the
// expected sequence and counts mismatching words in a saturating counter.
// Optional feature: define LFSR_CHK_ZERO_DETECT_EN to flag all-zero words
// (zero_err) and force reacquisition; otherwise zero_err is tied low.
// LOCK_CNT and LOSS_CNT are legal in the range 1..15.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clear_count,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic              zero_err
);

  chk_state_e        state_q;
  logic [LFSR_W-1:0] expected_q;
  logic [RUN_W-1:0]  run_q;
  logic [RUN_W-1:0]  miss_q;
  logic              locked_q;
  logic              err_pulse_q;
  logic              zero_err_q;
  logic [CNT_W-1:0]  err_count_q;
  logic [CNT_W-1:0]  err_count_d;

  logic [LFSR_W-1:0] data_next_c;
  logic [LFSR_W-1:0] exp_next_c;
  logic              match_c;
  logic              zero_word_c;
  logic              err_hit_c;
  logic [RUN_W-1:0]  run_inc_c;
  logic [RUN_W-1:0]  miss_inc_c;
  logic              lock_hit_c;
  logic              loss_hit_c;

  // Successor of the received word (used to seed expected on (re)acquisition)
  lfsr_step u_step_data (
    .d_i    (in_data),
    .next_o (data_next_c)
  );

  // Successor of the expected word (used while tracking a matching stream)
  lfsr_step u_step_exp (
    .d_i    (expected_q),
    .next_o (exp_next_c)
  );

  assign match_c    = (in_data == expected_q);
  assign run_inc_c  = run_q + RUN_W'(1);
  assign miss_inc_c = miss_q + RUN_W'(1);
  assign lock_hit_c = (run_inc_c == RUN_W'(LOCK_CNT));
  assign loss_hit_c = (miss_inc_c == RUN_W'(LOSS_CNT));

`ifdef LFSR_CHK_ZERO_DETECT_EN
  // All-zero word is illegal for a running LFSR: flag it and reacquire
  assign zero_word_c = in_valid && (in_data == '0);
`else
  // Zero words are treated as ordinary data
  assign zero_word_c = 1'b0;
`endif

  // A word counts as an error only while locked (mismatch or illegal zero)
  assign err_hit_c = in_valid && (state_q == ST_LOCKED) && (zero_word_c || !match_c);

  // Synchronisation FSM with its counters, expected word and registered flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      expected_q  <= LFSR_SEED;
      run_q       <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      zero_err_q  <= 1'b0;
    end else begin
      err_pulse_q <= err_hit_c;
      zero_err_q  <= zero_word_c;
      if (in_valid) begin
        if (zero_word_c) begin
          state_q  <= ST_HUNT;
          run_q    <= '0;
          miss_q   <= '0;
          locked_q <= 1'b0;
        end else begin
          unique case (state_q)
            ST_HUNT: begin
              expected_q <= data_next_c;
              run_q      <= '0;
              state_q    <= ST_SYNC;
            end
            ST_SYNC: begin
              if (match_c) begin
                expected_q <= exp_next_c;
                run_q      <= run_inc_c;
                if (lock_hit_c) begin
                  state_q  <= ST_LOCKED;
                  miss_q   <= '0;
                  locked_q <= 1'b1;
                end
              end else begin
                expected_q <= data_next_c;
                run_q      <= '0;
              end
            end
            ST_LOCKED: begin
              expected_q <= exp_next_c;
              if (match_c) begin
                miss_q <= '0;
              end else if (loss_hit_c) begin
                state_q  <= ST_HUNT;
                miss_q   <= '0;
                run_q    <= '0;
                locked_q <= 1'b0;
              end else begin
                miss_q <= miss_inc_c;
              end
            end
            default: begin
              state_q  <= ST_HUNT;
              run_q    <= '0;
              miss_q   <= '0;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Saturating error counter; a clear wins over a coincident error
  always_comb begin
    err_count_d = err_count_q;
    if (clear_count) begin
      err_count_d = '0;
    end else if (err_hit_c && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  // Error counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign zero_err  = zero_err_q;

endmodule : lfsr_checker

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench for lfsr_checker. A reference model
// pushes the expected outputs for each driven cycle; they are popped and
// compared one cycle later. A second instance exercises counter saturation.
module tb_lfsr_checker;

  localparam int unsigned LOCK_N = 4;
  localparam int unsigned LOSS_N = 3;
  localparam logic [12:0] SEED   = 13'h000F;
`ifdef LFSR_CHK_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  typedef struct {
    logic        locked;
    logic        err_pulse;
    logic [15:0] cnt;
    logic        zero;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [12:0] in_data;
  logic        clear_count;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        zero_err;

  logic        s_valid;
  logic [12:0] s_data;
  logic        s_clear;
  logic        s_locked;
  logic        s_err_pulse;
  logic [15:0] s_err_count;
  logic        s_zero_err;

  int          n_checks;
  int          n_errors;
  string       phase;
  exp_t        sb_q[$];

  // Reference model state (0 = hunt, 1 = sync, 2 = locked)
  int          m_st;
  logic [12:0] m_exp;
  int          m_run;
  int          m_miss;
  logic [15:0] m_cnt;
  logic [12:0] gen;
  logic [12:0] s_gen;

  lfsr_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .clear_count (clear_count),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .zero_err    (zero_err)
  );

  lfsr_checker #(.LOCK_CNT(1), .LOSS_CNT(15)) dut_sat (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (s_valid),
    .in_data     (s_data),
    .clear_count (s_clear),
    .locked      (s_locked),
    .err_pulse   (s_err_pulse),
    .err_count   (s_err_count),
    .zero_err    (s_zero_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [12:0] ref_next(input logic [12:0] d);
    logic fb;
    fb = d[12] ^ d[3] ^ d[2] ^ d[0];
    return {d[11:0], fb};
  endfunction

  // Flip bit 5 of a word, avoiding an accidental all-zero word
  function automatic logic [12:0] corrupt(input logic [12:0] g);
    logic [12:0] c;
    c = g ^ 13'h0020;
    if (c == 13'h0000) c = g ^ 13'h0040;
    return c;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_exp  = SEED;
    m_run  = 0;
    m_miss = 0;
    m_cnt  = 16'h0000;
  endtask

  // Advance the reference model by one cycle and push its expected outputs
  task automatic model_step(input logic v, input logic [12:0] d, input logic clr);
    exp_t e;
    logic ep;
    logic ze;
    ep = 1'b0;
    ze = 1'b0;
    if (v) begin
      if (ZD && (d == 13'h0000)) begin
        ze     = 1'b1;
        ep     = (m_st == 2);
        m_st   = 0;
        m_run  = 0;
        m_miss = 0;
      end else if (m_st == 0) begin
        m_exp = ref_next(d);
        m_run = 0;
        m_st  = 1;
      end else if (m_st == 1) begin
        if (d == m_exp) begin
          m_run++;
          m_exp = ref_next(m_exp);
          if (m_run == int'(LOCK_N)) begin
            m_st   = 2;
            m_miss = 0;
          end
        end else begin
          m_exp = ref_next(d);
          m_run = 0;
        end
      end else begin
        if (d == m_exp) begin
          m_miss = 0;
        end else begin
          ep = 1'b1;
          m_miss++;
          if (m_miss == int'(LOSS_N)) begin
            m_st   = 0;
            m_miss = 0;
            m_run  = 0;
          end
        end
        m_exp = ref_next(m_exp);
      end
    end
    if (clr) m_cnt = 16'h0000;
    else if (ep && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    e.locked    = (m_st == 2);
    e.err_pulse = ep;
    e.cnt       = m_cnt;
    e.zero      = ze;
    sb_q.push_back(e);
  endtask

  // Drive one cycle on the main DUT, then pop and compare its outputs
  task automatic cycle(input logic v, input logic [12:0] d, input logic clr);
    exp_t e;
    in_valid    = v;
    in_data     = d;
    clear_count = clr;
    model_step(v, d, clr);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s.sb: got empty queue expected one entry", phase);
    end else begin
      e = sb_q.pop_front();
      check_eq({phase, ".locked"},    32'(locked),    32'(e.locked));
      check_eq({phase, ".err_pulse"}, 32'(err_pulse), 32'(e.err_pulse));
      check_eq({phase, ".err_count"}, 32'(err_count), 32'(e.cnt));
      check_eq({phase, ".zero_err"},  32'(zero_err),  32'(e.zero));
    end
  endtask

  task automatic send_clean();
    cycle(1'b1, gen, 1'b0);
    gen = ref_next(gen);
  endtask

  task automatic send_bad();
    cycle(1'b1, corrupt(gen), 1'b0);
    gen = ref_next(gen);
  endtask

  // Drive one cycle on the saturation instance (checked explicitly)
  task automatic s_send(input logic bad, input logic clr);
    s_valid = 1'b1;
    s_data  = bad ? corrupt(s_gen) : s_gen;
    s_clear = clr;
    s_gen   = ref_next(s_gen);
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    s_clear = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    phase       = "reset";
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    clear_count = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    s_clear     = 1'b0;
    model_reset();
    gen   = SEED;
    s_gen = SEED;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst.locked",    32'(locked),    32'(0));
    check_eq("rst.err_pulse", 32'(err_pulse), 32'(0));
    check_eq("rst.err_count", 32'(err_count), 32'(0));
    check_eq("rst.zero_err",  32'(zero_err),  32'(0));
    reset = 1'b0;

    // Clean stream acquires lock after 1 + LOCK_CNT words
    phase = "acquire";
    repeat (LOCK_N) send_clean();
    check_eq("acquire.not_yet", 32'(locked), 32'(0));
    send_clean();
    check_eq("acquire.locked", 32'(locked), 32'(1));
    repeat (10) send_clean();

    // Single bit-5 flip while locked
    phase = "bitflip";
    send_bad();
    check_eq("bitflip.pulse", 32'(err_pulse), 32'(1));
    check_eq("bitflip.count", 32'(err_count), 32'(1));
    check_eq("bitflip.locked", 32'(locked), 32'(1));
    repeat (5) send_clean();
    check_eq("bitflip.pulse_gone", 32'(err_pulse), 32'(0));

    // Clear, then LOSS_CNT consecutive errors drop lock; clean stream resyncs
    phase = "loss";
    cycle(1'b0, 13'h1ABC, 1'b1);
    check_eq("loss.cleared", 32'(err_count), 32'(0));
    repeat (LOSS_N - 1) send_bad();
    check_eq("loss.still_locked", 32'(locked), 32'(1));
    send_bad();
    check_eq("loss.unlocked", 32'(locked), 32'(0));
    check_eq("loss.count", 32'(err_count), 32'(3));
    repeat (1 + LOCK_N) send_clean();
    check_eq("loss.relocked", 32'(locked), 32'(1));
    check_eq("loss.count_held", 32'(err_count), 32'(3));

    // Random idle gaps inside a clean stream
    phase = "gaps";
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 4)) cycle(1'b0, 13'($urandom), 1'b0);
      send_clean();
    end
    check_eq("gaps.locked", 32'(locked), 32'(1));
    check_eq("gaps.count", 32'(err_count), 32'(3));

    // All-zero word handling
    phase = "zero";
    if (ZD) begin
      cycle(1'b1, 13'h0000, 1'b0);
      gen = ref_next(gen);
      check_eq("zero.flag", 32'(zero_err), 32'(1));
      check_eq("zero.count", 32'(err_count), 32'(4));
      check_eq("zero.unlocked", 32'(locked), 32'(0));
    end else begin
      repeat (10) cycle(1'b1, 13'h0000, 1'b0);
      check_eq("zero.locked", 32'(locked), 32'(1));
      check_eq("zero.flag", 32'(zero_err), 32'(0));
    end
    repeat (8) send_clean();
    check_eq("zero.relocked", 32'(locked), 32'(1));

    // Reset asserted mid-cycle aborts at once; reacquire without errors
    phase = "midrst";
    in_valid = 1'b1;
    in_data  = gen;
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst.locked",    32'(locked),    32'(0));
    check_eq("midrst.err_count", 32'(err_count), 32'(0));
    check_eq("midrst.err_pulse", 32'(err_pulse), 32'(0));
    check_eq("midrst.zero_err",  32'(zero_err),  32'(0));
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    gen = 13'h0A55;
    repeat (1 + LOCK_N) send_clean();
    check_eq("midrst.relocked", 32'(locked), 32'(1));
    check_eq("midrst.no_err", 32'(err_count), 32'(0));
    repeat (3) send_clean();

    // Saturation on the second instance (LOCK_CNT=1, LOSS_CNT=15)
    phase = "sat";
    s_send(1'b0, 1'b0);
    s_send(1'b0, 1'b0);
    check_eq("sat.locked", 32'(s_locked), 32'(1));
    for (int b = 0; b < 4681; b++) begin
      repeat (14) s_send(1'b1, 1'b0);
      s_send(1'b0, 1'b0);
    end
    check_eq("sat.fffe", 32'(s_err_count), 32'(16'hFFFE));
    check_eq("sat.still_locked", 32'(s_locked), 32'(1));
    s_send(1'b1, 1'b0);
    check_eq("sat.ffff", 32'(s_err_count), 32'(16'hFFFF));
    check_eq("sat.pulse", 32'(s_err_pulse), 32'(1));
    repeat (2) s_send(1'b1, 1'b0);
    check_eq("sat.hold", 32'(s_err_count), 32'(16'hFFFF));
    s_send(1'b1, 1'b1);
    check_eq("sat.clear_wins", 32'(s_err_count), 32'(0));
    check_eq("sat.zero_err", 32'(s_zero_err), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_lfsr_checker
